// File: rtl/free_list.sv
// Physical-register free list for a renaming mapper.
// Tags live in a circular buffer; spec_head serves speculative allocations,
// commit_head trails it as the ROB retires allocating uops, and tail receives
// tags returned at retire. A flush rewinds spec_head to the retired position.
module free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int TAG_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             retire_alloc,
    input  logic             free_valid,
    input  logic [TAG_W-1:0] free_tag,
    input  logic             flush,
    output logic [TAG_W:0]   free_count,
    output logic             overflow_err
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]   r_spec_head;
    logic [TAG_W:0]   r_commit_head;
    logic [TAG_W:0]   r_tail;
    logic             r_overflow_err;
    logic [TAG_W-1:0] r_buf [NUM_PREGS];

    logic [TAG_W:0]   w_free_count;
    logic [TAG_W:0]   w_in_flight;
    logic [TAG_W:0]   w_commit_next;
    logic             w_alloc_grant;
    logic             w_free_live;
    logic             w_free_ok;
    logic             w_free_ovf;
    logic             w_ret_ok;
    logic             w_ret_ovf;

    // Tags between commit_head and tail are owned by the list (free or
    // speculatively handed out); that span may never exceed the buffer size.
    assign w_free_count  = r_tail - r_spec_head;
    assign w_in_flight   = r_tail - r_commit_head;
    assign w_alloc_grant = alloc_req && alloc_valid && !flush;
    // Tag 0 backs the permanent x0 mapping and is never recycled.
    assign w_free_live   = free_valid && (free_tag != '0);
    assign w_free_ok     = w_free_live && (w_in_flight < (TAG_W+1)'(NUM_PREGS));
    assign w_free_ovf    = w_free_live && !(w_in_flight < (TAG_W+1)'(NUM_PREGS));
    assign w_ret_ok      = retire_alloc && (r_commit_head != r_spec_head);
    assign w_ret_ovf     = retire_alloc && (r_commit_head == r_spec_head);
    // A flush lands on the commit position including this cycle's retirement.
    assign w_commit_next = r_commit_head + {{TAG_W{1'b0}}, w_ret_ok};

    assign alloc_valid  = (w_free_count != '0);
    assign alloc_tag    = r_buf[r_spec_head[TAG_W-1:0]];
    assign free_count   = w_free_count;
    assign overflow_err = r_overflow_err;

    // Pointer and sticky-error update; alloc, free and retire act independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spec_head    <= '0;
            r_commit_head  <= '0;
            r_tail         <= (TAG_W+1)'(NUM_PREGS - NUM_AREGS);
            r_overflow_err <= 1'b0;
        end else begin
            r_commit_head <= w_commit_next;
            if (flush)
                r_spec_head <= w_commit_next;
            else if (w_alloc_grant)
                r_spec_head <= r_spec_head + 1'b1;
            if (w_free_ok)
                r_tail <= r_tail + 1'b1;
            if (w_free_ovf || w_ret_ovf)
                r_overflow_err <= 1'b1;
        end
    end

    // Tag storage: reset seeds the non-architectural tags, frees append at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                if (i < NUM_PREGS - NUM_AREGS)
                    r_buf[i] <= TAG_W'(NUM_AREGS + i);
                else
                    r_buf[i] <= '0;
            end
        end else if (w_free_ok) begin
            r_buf[r_tail[TAG_W-1:0]] <= free_tag;
        end
    end

endmodule
